// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and main memory.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [3:0]    DATA_MEM_READ,
    input  logic [2:0]    DATA_MEM_WRITE,
    input  logic [31:0]   DATA_MEM_ADDR,
    input  logic [31:0]   DATA_MEM_WRITE_DATA,
    output logic [31:0]   DATA_MEM_READ_DATA,
    output logic          DATA_MEM_BUSYWAIT,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [27:0]   MEM_ADDR,
    output logic [127:0]  MEM_WRITE_DATA,
    input  logic [127:0]  MEM_READ_DATA,
`ifdef DCACHE_STATS_EN
    output logic [31:0]   HIT_COUNT,
    output logic [31:0]   MISS_COUNT,
`endif
    input  logic          MEM_BUSYWAIT
);

    localparam int TAG_W = 28 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [LINES-1:0]      valid, dirty;
    logic [TAG_W-1:0]      tags   [LINES];
    logic [127:0]          blocks [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            woff;
    logic                  ld, st, req, hit;
    logic [31:0]           word, merged;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    assign idx  = DATA_MEM_ADDR[3+INDEX_BITS:4];
    assign tag  = DATA_MEM_ADDR[31:4+INDEX_BITS];
    assign woff = DATA_MEM_ADDR[3:2];
    assign ld   = DATA_MEM_READ[3];
    assign st   = DATA_MEM_WRITE[2];
    assign req  = ld | st;
    assign hit  = req && valid[idx] && (tags[idx] == tag);

    assign word = blocks[idx][{woff, 5'b0} +: 32];
    assign bsel = word[{DATA_MEM_ADDR[1:0], 3'b0} +: 8];
    assign hsel = word[{DATA_MEM_ADDR[1], 4'b0} +: 16];

    assign DATA_MEM_BUSYWAIT = (state != IDLE) || (req && !hit);

    // Load result only on a pure load hit; a simultaneous store wins and reads back zero.
    always_comb begin
        DATA_MEM_READ_DATA = '0;
        if (state == IDLE && hit && ld && !st) begin
            case (DATA_MEM_READ[2:0])
                3'b000:  DATA_MEM_READ_DATA = {{24{bsel[7]}}, bsel};
                3'b001:  DATA_MEM_READ_DATA = {{16{hsel[15]}}, hsel};
                3'b100:  DATA_MEM_READ_DATA = {24'b0, bsel};
                3'b101:  DATA_MEM_READ_DATA = {16'b0, hsel};
                default: DATA_MEM_READ_DATA = word;
            endcase
        end
    end

    always_comb begin
        merged = word;
        case (DATA_MEM_WRITE[1:0])
            2'b00:   merged[{DATA_MEM_ADDR[1:0], 3'b0} +: 8] = DATA_MEM_WRITE_DATA[7:0];
            2'b01:   merged[{DATA_MEM_ADDR[1], 4'b0} +: 16] = DATA_MEM_WRITE_DATA[15:0];
            default: merged = DATA_MEM_WRITE_DATA;
        endcase
    end

    always_comb begin
        MEM_READ       = 1'b0;
        MEM_WRITE      = 1'b0;
        MEM_ADDR       = '0;
        MEM_WRITE_DATA = '0;
        state_nxt      = state;
        case (state)
            IDLE: begin
                if (req && !hit)
                    state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                MEM_WRITE      = 1'b1;
                MEM_ADDR       = {tags[idx], idx};
                MEM_WRITE_DATA = blocks[idx];
                if (!MEM_BUSYWAIT) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                MEM_READ = 1'b1;
                MEM_ADDR = DATA_MEM_ADDR[31:4];
                if (!MEM_BUSYWAIT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && st && hit) begin
                dirty[idx] <= 1'b1;
            end else if (state == ALLOCATE && !MEM_BUSYWAIT) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == IDLE && st && hit) begin
                blocks[idx][{woff, 5'b0} +: 32] <= merged;
            end else if (state == ALLOCATE && !MEM_BUSYWAIT) begin
                blocks[idx] <= MEM_READ_DATA;
                tags[idx]   <= tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else if (state == IDLE && req) begin
            if (hit) HIT_COUNT  <= HIT_COUNT + 32'd1;
            else     MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: flat reference memory predicts loads and write-backs,
// a latency-programmable main memory model answers block requests.
module tb_dcache_controller;

    localparam int LAT = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [3:0]    DATA_MEM_READ;
    logic [2:0]    DATA_MEM_WRITE;
    logic [31:0]   DATA_MEM_ADDR;
    logic [31:0]   DATA_MEM_WRITE_DATA;
    logic [31:0]   DATA_MEM_READ_DATA;
    logic          DATA_MEM_BUSYWAIT;
    logic          MEM_READ, MEM_WRITE;
    logic [27:0]   MEM_ADDR;
    logic [127:0]  MEM_WRITE_DATA;
    logic [127:0]  MEM_READ_DATA;
    logic          MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [31:0]   HIT_COUNT, MISS_COUNT;
`endif

    dcache_controller #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
        .DATA_MEM_ADDR(DATA_MEM_ADDR), .DATA_MEM_WRITE_DATA(DATA_MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA(DATA_MEM_READ_DATA), .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int b, input int w);
        if (b == 0 && w == 0) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | 32'(b << 8) | 32'(w);
    endfunction

    // Main memory (block granular) and the CPU-visible reference (word granular).
    logic [127:0] mem  [64];
    logic [31:0]  rmem [256];
    logic [127:0] wbq [$];
    logic [31:0]  rdq [$];
    int           cnt = 0;

    initial begin
        for (int b = 0; b < 64; b++) begin
            for (int w = 0; w < 4; w++) begin
                mem[b][w*32 +: 32] = init_word(b, w);
                rmem[b*4+w]        = init_word(b, w);
            end
        end
    end

    assign MEM_BUSYWAIT  = (MEM_READ | MEM_WRITE) && (cnt != LAT);
    assign MEM_READ_DATA = mem[MEM_ADDR[5:0]];

    always @(posedge CLK) begin
        if (MEM_READ | MEM_WRITE) begin
            if (cnt == LAT) begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    mem[MEM_ADDR[5:0]] <= MEM_WRITE_DATA;
                    if (wbq.size() > 0) chk("wb_data", MEM_WRITE_DATA, wbq.pop_front());
                    else                chk("wb_unexpected", 1, 0);
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[a*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    int          exp_hit = 0, exp_miss = 0;
    logic        saw_rd, saw_wr, saw_both = 1'b0;
    logic [27:0] last_ra, last_wa;

    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_cyc, input string tag);
        int ci;
        int cyc;
        ci = int'(a[9:2]);
        if (rd[3]) rdq.push_back(wr[2] ? 32'h0 : ext(rmem[ci], rd[2:0], a[1:0]));
        if (wr[2]) begin
            case (wr[1:0])
                2'b00:   rmem[ci][a[1:0]*8 +: 8]  = wd[7:0];
                2'b01:   rmem[ci][a[1]*16 +: 16]  = wd[15:0];
                default: rmem[ci]                 = wd;
            endcase
        end
        DATA_MEM_READ = rd; DATA_MEM_WRITE = wr; DATA_MEM_ADDR = a; DATA_MEM_WRITE_DATA = wd;
        saw_rd = 1'b0; saw_wr = 1'b0; last_ra = '0; last_wa = '0;
        #1;
        cyc = 1;
        while (DATA_MEM_BUSYWAIT && cyc < 100) begin
            @(negedge CLK); #1;
            cyc++;
            if (MEM_READ && MEM_WRITE) saw_both = 1'b1;
            if (MEM_READ && !saw_rd)  begin saw_rd = 1'b1; last_ra = MEM_ADDR; end
            if (MEM_WRITE && !saw_wr) begin saw_wr = 1'b1; last_wa = MEM_ADDR; end
        end
        chk({tag, "_busy"}, DATA_MEM_BUSYWAIT, 0);
        chk({tag, "_lat"}, cyc, exp_cyc);
        if (rd[3]) chk({tag, "_data"}, DATA_MEM_READ_DATA, rdq.pop_front());
        if (exp_cyc > 1) chk({tag, "_fetch"}, last_ra, a[31:4]);
        exp_hit++;
        if (exp_cyc > 1) exp_miss++;
        @(negedge CLK);
        DATA_MEM_READ = '0; DATA_MEM_WRITE = '0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hits"}, HIT_COUNT, exp_hit);
        chk({tag, "_miss"}, MISS_COUNT, exp_miss);
`else
        chk({tag, "_nostats"}, DATA_MEM_BUSYWAIT, 0);
`endif
    endtask

    localparam int CLEAN = LAT + 3;
    localparam int DIRTY = 2 * (LAT + 1) + 2;

    initial begin
        RESET = 1'b1;
        DATA_MEM_READ = '0; DATA_MEM_WRITE = '0; DATA_MEM_ADDR = '0; DATA_MEM_WRITE_DATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy",  DATA_MEM_BUSYWAIT, 0);
        chk("rst_rdata", DATA_MEM_READ_DATA, 0);
        chk("rst_mrd",   MEM_READ, 0);
        chk("rst_mwr",   MEM_WRITE, 0);
        chk("rst_maddr", MEM_ADDR, 0);
        chk("rst_mwdat", MEM_WRITE_DATA, 0);
        chk_stats("rst");
        RESET = 1'b0;
        @(negedge CLK);

        access(4'b1010, 3'b000, 32'h00, 0, CLEAN, "lw_cold");
        chk("lw_cold_nowb", saw_wr, 0);
        access(4'b0000, 3'b110, 32'h00, 32'h80FF_0000, 1, "sw0");
        access(4'b1000, 3'b000, 32'h03, 0, 1, "lb3");
        access(4'b1100, 3'b000, 32'h03, 0, 1, "lbu3");
        access(4'b1001, 3'b000, 32'h02, 0, 1, "lh2");
        access(4'b1101, 3'b000, 32'h02, 0, 1, "lhu2");
        access(4'b1000, 3'b000, 32'h02, 0, 1, "lb2");
        access(4'b1010, 3'b000, 32'h00, 0, 1, "lw0a");
        access(4'b0000, 3'b110, 32'h00, 32'h1122_3344, 1, "sw0b");
        access(4'b0000, 3'b100, 32'h01, 32'h0000_00AB, 1, "sb1");
        access(4'b1010, 3'b000, 32'h00, 0, 1, "lw0b");
        access(4'b0000, 3'b101, 32'h02, 32'hFFFF_5566, 1, "sh2");
        access(4'b1010, 3'b000, 32'h00, 0, 1, "lw0c");
        access(4'b0000, 3'b110, 32'h0B, 32'h0102_0304, 1, "sw_unal");
        access(4'b1010, 3'b000, 32'h08, 0, 1, "lw8");
        access(4'b0000, 3'b110, 32'h04, 32'hCAFE_F00D, 1, "sw4");
        access(4'b1010, 3'b110, 32'h0C, 32'h7777_7777, 1, "ld_st");
        access(4'b1010, 3'b000, 32'h0C, 0, 1, "lwC");
        #1;
        chk("idle_busy",  DATA_MEM_BUSYWAIT, 0);
        chk("idle_rdata", DATA_MEM_READ_DATA, 0);

        wbq.push_back({rmem[3], rmem[2], rmem[1], rmem[0]});
        access(4'b1010, 3'b000, 32'h84, 0, DIRTY, "lw84");
        chk("wb_seen", saw_wr, 1);
        chk("wb_addr", last_wa, 0);
        access(4'b1010, 3'b000, 32'h04, 0, CLEAN, "lw4_back");
        access(4'b1000, 3'b000, 32'h85, 0, CLEAN, "lb85");
        chk_stats("mid");

        // Abort a fill with RESET; the line must come back invalid.
        DATA_MEM_READ = 4'b1010; DATA_MEM_ADDR = 32'h40;
        #1; chk("abort_busy", DATA_MEM_BUSYWAIT, 1);
        @(negedge CLK); #1;
        chk("abort_alloc", MEM_READ, 1);
        chk("abort_maddr", MEM_ADDR, 28'h4);
        RESET = 1'b1;
        @(negedge CLK); #1;
        chk("abort_mrd", MEM_READ, 0);
        chk("abort_mwr", MEM_WRITE, 0);
        DATA_MEM_READ = '0;
        @(negedge CLK);
        RESET = 1'b0;
        exp_hit = 0; exp_miss = 0;
        chk_stats("abort");
        access(4'b1010, 3'b000, 32'h00, 0, CLEAN, "lw0_rst");
        access(4'b1010, 3'b000, 32'h40, 0, CLEAN, "lw40_rst");

        chk("never_both", saw_both, 0);
        chk("wbq_left", wbq.size(), 0);
        chk("rdq_left", rdq.size(), 0);
        chk_stats("end");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache that sits between the CPU MEM stage and the main data memory. It consumes the CPU's load/store control, address and store data, and returns load data and a busy-wait signal that stalls the pipeline. Misses are serviced through a block-wide handshake to main memory: dirty victims are written back, then the missing 16-byte block is fetched.

## Interface
Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 lines); tag width = 28 - INDEX_BITS.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- DATA_MEM_READ  in  4  [3] = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- DATA_MEM_WRITE  in  3  [2] = store enable; [1:0] = size (00 SB, 01 SH, 10 SW).
- DATA_MEM_ADDR  in  32  byte address; [3:2] word offset, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- DATA_MEM_WRITE_DATA  in  32  store data, right-aligned.
- DATA_MEM_READ_DATA  out  32  load result, sign/zero-extended per funct3.
- DATA_MEM_BUSYWAIT  out  1  high while the request cannot complete this cycle.
- MEM_READ  out  1  block fetch request to main memory.
- MEM_WRITE  out  1  block write-back request to main memory.
- MEM_ADDR  out  28  block address (byte address >> 4).
- MEM_WRITE_DATA  out  128  victim block; word 0 in [31:0].
- MEM_READ_DATA  in  128  fetched block; word 0 in [31:0].
- MEM_BUSYWAIT  in  1  high while main memory is busy with the current request.

## Operation
- Per line: valid bit, dirty bit, tag, 4x32-bit data words.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE: hit = valid & tag match & (load or store). Hit load: output the selected word, extracted by byte (addr[1:0]) or halfword (addr[1]), extended per funct3. Hit store: merge bytes into the word at posedge and set dirty. SB uses lane addr[1:0]. SH uses lane addr[1]. SW writes the whole word; addr[1:0] are ignored.
- Miss in IDLE: dirty victim goes to WRITEBACK, otherwise to ALLOCATE.
- WRITEBACK: MEM_WRITE=1, MEM_ADDR={victim tag, index}, MEM_WRITE_DATA=victim block. On the first posedge with MEM_BUSYWAIT=0 (after at least one cycle in the state), go to ALLOCATE.
- ALLOCATE: MEM_READ=1, MEM_ADDR=request block. On the first posedge with MEM_BUSYWAIT=0 (after at least one cycle in the state), write the block, set valid=1, dirty=0, load the new tag, and go to IDLE. The replayed request then hits.
- Load and store enables both set: the store takes priority and DATA_MEM_READ_DATA=0.
- No request: DATA_MEM_BUSYWAIT=0, DATA_MEM_READ_DATA=0.

## Timing
- Reset values: all valid and dirty bits 0, state IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WRITE_DATA=0, DATA_MEM_BUSYWAIT=0, DATA_MEM_READ_DATA=0.
- Hit: zero-wait. BUSYWAIT stays low and load data is combinational in the same cycle. The store is written at the ending posedge.
- Miss: BUSYWAIT rises combinationally in the request cycle and stays high in WRITEBACK and ALLOCATE. It falls in the IDLE cycle after allocation.
- Latency, clean miss: 1 + N_alloc + 1 cycles, where N_alloc = cycles in ALLOCATE.
- Latency, dirty miss: adds N_wb write-back cycles.
- MEM_READ/MEM_WRITE stay stable until the memory handshake completes. They are never both high.
- Request inputs are held stable by the stalled CPU during a miss and are re-sampled in IDLE.
- RESET mid-miss: state returns to IDLE and MEM_* deassert the next cycle. The partially handled line stays invalid, since all valid bits clear.
- Index wrap: address 0x80 with INDEX_BITS=3 maps to index 0 with tag 1.

## Configuration
- DCACHE_STATS_EN defined: adds outputs HIT_COUNT and MISS_COUNT, each 32-bit.
  - Each increments once per request resolved in IDLE: a hit, or a miss detection.
  - Replays after allocation count as hits.
  - Both counters are cleared by RESET and wrap at 2^32.
- DCACHE_STATS_EN undefined: the ports and counters are absent, with no other change.

## Test plan
- Reset, then LW 0x00 (cold) -> BUSYWAIT high and MEM_READ=1 with MEM_ADDR=0; memory returns a block with word0=0xDEADBEEF; BUSYWAIT falls one cycle after ALLOCATE and READ_DATA=0xDEADBEEF.
- LB 0x03 on a line holding 0x80FF_0000 -> 0xFFFF_FF80. LBU 0x03 -> 0x0000_0080. LH 0x02 -> 0xFFFF_80FF.
- SB 0x01 data 0xAB to the word 0x11223344 -> zero-wait; a following LW 0x00 reads 0x1122AB44.
- Store to 0x04 (dirty), then LW 0x84 -> WRITEBACK with MEM_ADDR=0x0 carrying the merged block, then ALLOCATE with MEM_ADDR=0x8, then the load returns the new data.
- RESET asserted during ALLOCATE -> MEM_READ=0 the next cycle; re-issuing LW 0x00 misses again.
- With DCACHE_STATS_EN: run the sequence above -> HIT_COUNT and MISS_COUNT match the expected tallies.
